// File: rtl/ddr3_mcb_port_responder.sv
// ddr3_mcb_port_responder: MCB-style user port responder
// backed by an on-chip word RAM with cmd/write/read FIFOs.
module ddr3_mcb_port_responder #(
  parameter int ADDR_WIDTH     = 10,
  parameter int CMD_DEPTH      = 4,
  parameter int READ_LATENCY   = 4,
  parameter int REFRESH_CYCLES = 8,
  parameter int CAL_CYCLES     = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        calibration_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [27:0] cmd_word_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);
  localparam int CW = $clog2(CMD_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_BURST,
    READ_WAIT,
    READ_BURST,
    REFRESH
  } state_t;

  state_t state_q, state_d;

  logic       cal_q;
  logic [7:0] cal_cnt_q;

  logic [2:0]            cq_instr [CMD_DEPTH];
  logic [5:0]            cq_bl    [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] cq_addr  [CMD_DEPTH];
  logic [CW-1:0]         cq_wp, cq_rp;
  logic [CW:0]           cq_cnt;
  logic                  cmd_push, cmd_pop;

  logic [35:0] wf_mem [64];
  logic [5:0]  wf_wp, wf_rp;
  logic [6:0]  wf_cnt;
  logic        wf_push, wf_pop;
  logic [35:0] wf_head;

  logic [31:0] rf_mem [64];
  logic [5:0]  rf_wp, rf_rp;
  logic [6:0]  rf_cnt;
  logic        rf_req, rf_push, rf_pop;
  logic [31:0] rd_data_q, rd_data_d;

  logic [31:0] ram [2**ADDR_WIDTH];
  logic [31:0] ram_rd, wr_word;
  logic        ram_we;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [5:0]            bl_q, bl_d;
  logic [7:0]            cnt_q, cnt_d;

  logic unused_addr_hi;
  assign unused_addr_hi = ^cmd_word_addr[27:ADDR_WIDTH];

  assign calibration_done = cal_q;
  assign cmd_empty = (cq_cnt == '0);
  assign cmd_full  = (cq_cnt == (CW+1)'(CMD_DEPTH));
  assign wr_empty  = (wf_cnt == 7'd0);
  assign wr_full   = (wf_cnt == 7'd64);
  assign wr_count  = wf_cnt;
  assign rd_empty  = (rf_cnt == 7'd0);
  assign rd_full   = (rf_cnt == 7'd64);
  assign rd_count  = rf_cnt;
  assign rd_data   = rd_data_q;

  assign cmd_push = cal_q & cmd_en & ~cmd_full;
  assign wf_push  = cal_q & wr_en & ~wr_full;
  assign wf_pop   = (state_q == WRITE_BURST) & ~wr_empty;
  assign rf_req   = (state_q == READ_BURST);
  assign rf_push  = rf_req & ~rd_full;
  assign rf_pop   = cal_q & rd_en & ~rd_empty;
  assign ram_we   = (state_q == WRITE_BURST);
  assign ram_rd   = ram[addr_q];
  assign wf_head  = wf_mem[wf_rp];

  // underrun writes a full zero word
  always_comb begin
    wr_word = 32'h0;
    if (!wr_empty) begin
      for (int b = 0; b < 4; b++) begin
        wr_word[8*b +: 8] = wf_head[32+b] ?
          ram_rd[8*b +: 8] : wf_head[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rf_push && (rf_cnt == 7'd0 ||
        (rf_cnt == 7'd1 && rf_pop))) begin
      rd_data_d = ram_rd;
    end else if (rf_pop && rf_cnt > 7'd1) begin
      rd_data_d = rf_mem[6'(rf_rp + 6'd1)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_q     <= 1'b0;
      cal_cnt_q <= '0;
    end else if (!cal_q) begin
      cal_cnt_q <= cal_cnt_q + 8'd1;
      if (cal_cnt_q == 8'(CAL_CYCLES - 1)) cal_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cq_wp       <= '0;
      cq_rp       <= '0;
      cq_cnt      <= '0;
      wf_wp       <= '0;
      wf_rp       <= '0;
      wf_cnt      <= '0;
      rf_wp       <= '0;
      rf_rp       <= '0;
      rf_cnt      <= '0;
      rd_data_q   <= '0;
      wr_underrun <= 1'b0;
      wr_error    <= 1'b0;
      rd_overflow <= 1'b0;
      rd_error    <= 1'b0;
    end else begin
      if (cmd_push) cq_wp <= cq_wp + 1'b1;
      if (cmd_pop)  cq_rp <= cq_rp + 1'b1;
      cq_cnt <= cq_cnt + (CW+1)'(cmd_push)
                       - (CW+1)'(cmd_pop);
      if (wf_push) wf_wp <= wf_wp + 6'd1;
      if (wf_pop)  wf_rp <= wf_rp + 6'd1;
      wf_cnt <= wf_cnt + 7'(wf_push) - 7'(wf_pop);
      if (rf_push) rf_wp <= rf_wp + 6'd1;
      if (rf_pop)  rf_rp <= rf_rp + 6'd1;
      rf_cnt <= rf_cnt + 7'(rf_push) - 7'(rf_pop);
      rd_data_q <= rd_data_d;
      if (ram_we && wr_empty)          wr_underrun <= 1'b1;
      if (cal_q && wr_en && wr_full)   wr_error    <= 1'b1;
      if (rf_req && rd_full)           rd_overflow <= 1'b1;
      if (cal_q && rd_en && rd_empty)  rd_error    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_instr[cq_wp] <= cmd_instr;
      cq_bl[cq_wp]    <= cmd_bl;
      cq_addr[cq_wp]  <= cmd_word_addr[ADDR_WIDTH-1:0];
    end
    if (wf_push) wf_mem[wf_wp] <= {wr_mask, wr_data};
    if (rf_push) rf_mem[rf_wp] <= ram_rd;
    if (ram_we)  ram[addr_q]   <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bl_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bl_q    <= bl_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bl_d    = bl_q;
    cnt_d   = cnt_q;
    cmd_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cal_q && !cmd_empty) begin
          cmd_pop = 1'b1;
          addr_d  = cq_addr[cq_rp];
          bl_d    = cq_bl[cq_rp];
          cnt_d   = '0;
          unique case (cq_instr[cq_rp])
            3'b000, 3'b010: state_d = WRITE_BURST;
            3'b001, 3'b011: state_d = (READ_LATENCY > 1) ?
                                      READ_WAIT : READ_BURST;
            3'b100:         state_d = REFRESH;
            default:        state_d = IDLE;
          endcase
        end
      end
      WRITE_BURST, READ_BURST: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q[5:0] == bl_q) state_d = IDLE;
      end
      READ_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(READ_LATENCY - 2)) begin
          state_d = READ_BURST;
          cnt_d   = '0;
        end
      end
      REFRESH: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(REFRESH_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr3_mcb_port_responder.sv
// tb_ddr3_mcb_port_responder: directed + random stimulus
// checked against a word-level model of the port.
module tb_ddr3_mcb_port_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        calibration_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [27:0] cmd_word_addr;
  logic        cmd_empty, cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full, wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun, wr_error;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full, rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow, rd_error;

  always #5 clk = ~clk;

  ddr3_mcb_port_responder dut (
    .clk(clk), .rst(rst),
    .calibration_done(calibration_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr),
    .cmd_bl(cmd_bl), .cmd_word_addr(cmd_word_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty),
    .wr_count(wr_count), .wr_underrun(wr_underrun),
    .wr_error(wr_error), .rd_en(rd_en), .rd_data(rd_data),
    .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow),
    .rd_error(rd_error)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [1024];
  logic [35:0] wq [$];
  logic [31:0] rq [$];
  logic        und_m  = 1'b0;
  logic        werr_m = 1'b0;
  logic        ovf_m  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_write(input int a, input int bl);
    logic [35:0] w;
    int x;
    for (int i = 0; i <= bl; i++) begin
      x = (a + i) % 1024;
      if (wq.size() > 0) begin
        w = wq.pop_front();
        for (int b = 0; b < 4; b++)
          if (!w[32+b]) ram_m[x][8*b +: 8] = w[8*b +: 8];
      end else begin
        ram_m[x] = 32'h0;
        und_m = 1'b1;
      end
    end
  endtask

  task automatic model_read(input int a, input int bl);
    for (int i = 0; i <= bl; i++) begin
      if (rq.size() < 64) rq.push_back(ram_m[(a + i) % 1024]);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic push_w(input logic [31:0] d,
                        input logic [3:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    @(negedge clk);
    wr_en = 1'b0;
    if (wq.size() < 64) wq.push_back({m, d});
    else werr_m = 1'b1;
  endtask

  task automatic send_cmd(input logic [2:0] ins,
                          input int bl, input int a);
    cmd_en = 1'b1; cmd_instr = ins;
    cmd_bl = 6'(bl); cmd_word_addr = 28'(a);
    @(negedge clk);
    cmd_en = 1'b0;
    if (ins == 3'b000 || ins == 3'b010) model_write(a, bl);
    else if (ins == 3'b001 || ins == 3'b011) model_read(a, bl);
  endtask

  task automatic wait_rd(input int n, input string tag);
    int t = 0;
    while (rd_count != 7'(n) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(rd_count), 32'(n));
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    e = rq.pop_front();
    chk(tag, rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_en = 1'b0; cmd_instr = '0;
    cmd_bl = '0; cmd_word_addr = '0;
    wr_en = 1'b0; wr_mask = '0; wr_data = '0; rd_en = 1'b0;
    idle(3);
    chk("rst_cal", 32'(calibration_done), 0);
    chk("rst_empties", {cmd_empty, wr_empty, rd_empty}, 3'b111);
    chk("rst_fulls", {cmd_full, wr_full, rd_full}, 3'b000);
    chk("rst_counts", {wr_count, rd_count}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sticky",
        {wr_underrun, wr_error, rd_overflow, rd_error}, 0);

    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wr_en = (k <= 8); rd_en = (k <= 8);
      cmd_en = (k <= 8); cmd_instr = 3'b100;
      @(negedge clk);
      chk("cal_rise", 32'(calibration_done), 32'(k >= 16));
    end
    wr_en = 1'b0; rd_en = 1'b0; cmd_en = 1'b0;
    idle(2);
    chk("precal_ignored",
        {cmd_empty, wr_empty, rd_empty, rd_error}, 4'b1110);

    for (int i = 0; i < 4; i++) push_w(32'hA0 + i, 4'h0);
    send_cmd(3'b000, 3, 'h10);
    send_cmd(3'b001, 3, 'h10);
    wait_rd(4, "basic_cnt");
    for (int i = 0; i < 4; i++) begin
      chk("basic_const", rd_data, 32'hA0 + i);
      pop_chk("basic_data");
    end

    push_w(32'hFFFF_FFFF, 4'h0);
    send_cmd(3'b000, 0, 5);
    push_w(32'h1234_5678, 4'b0101);
    send_cmd(3'b000, 0, 5);
    send_cmd(3'b001, 0, 5);
    wait_rd(1, "mask_cnt");
    chk("mask_rb", rd_data, 32'h12FF_56FF);
    pop_chk("mask_data");

    for (int it = 0; it < 4; it++) begin
      int a, bl;
      a  = $urandom_range(256, 700);
      bl = $urandom_range(0, 15);
      for (int i = 0; i <= bl; i++) push_w($urandom, 4'h0);
      send_cmd(3'b010, bl, a);
      for (int i = 0; i <= bl; i++)
        push_w($urandom, 4'($urandom));
      send_cmd(3'b000, bl, a);
      send_cmd(3'b011, bl, a);
      wait_rd(bl + 1, "rnd_cnt");
      for (int i = 0; i <= bl; i++) pop_chk("rnd_data");
    end
    chk("no_sticky",
        {wr_underrun, wr_error, rd_overflow, rd_error}, 0);

    push_w($urandom, 4'h0);
    push_w($urandom, 4'h0);
    send_cmd(3'b000, 7, 'h40);
    idle(15);
    chk("underrun", 32'(wr_underrun), 32'(und_m));
    send_cmd(3'b001, 7, 'h40);
    wait_rd(8, "und_cnt");
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) chk("und_zero", rd_data, 0);
      pop_chk("und_data");
    end

    for (int i = 0; i < 65; i++) push_w($urandom, 4'h0);
    chk("wr_error", 32'(wr_error), 32'(werr_m));
    chk("wr_full", {wr_full, wr_count}, {1'b1, 7'd64});
    send_cmd(3'b000, 63, 1022);
    send_cmd(3'b001, 63, 1022);
    wait_rd(64, "wrap_cnt");
    chk("rd_full", 32'(rd_full), 1);
    chk("wr_drained", 32'(wr_empty), 1);
    send_cmd(3'b001, 0, 0);
    idle(10);
    chk("rd_overflow", 32'(rd_overflow), 32'(ovf_m));
    chk("ovf_cnt", 32'(rd_count), 64);
    for (int i = 0; i < 64; i++) pop_chk("wrap_data");
    chk("rd_empty", 32'(rd_empty), 1);

    chk("rd_err_pre", 32'(rd_error), 0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_error", 32'(rd_error), 1);
    chk("rd_err_cnt", 32'(rd_count), 0);

    send_cmd(3'b100, 0, 0);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      int a;
      a = $urandom_range(0, 1023);
      cmd_en = 1'b1; cmd_instr = 3'b001;
      cmd_bl = 6'd0; cmd_word_addr = 28'(a);
      @(negedge clk);
      if (i < 4) model_read(a, 0);
    end
    cmd_en = 1'b0;
    chk("cmd_full", 32'(cmd_full), 1);
    wait_rd(4, "refresh_cnt");
    for (int i = 0; i < 4; i++) pop_chk("refresh_data");
    idle(4);
    chk("cmd_drop", {cmd_empty, rd_empty}, 2'b11);

    send_cmd(3'b111, 5, 0);
    idle(10);
    chk("noop", {cmd_empty, rd_empty, 7'(rd_count)},
        {2'b11, 7'd0});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
